// File: rtl/seq_detector_prog_if.sv
// Serial-pattern detector bus: bit stream, config load, match outputs.
// master = bit source/config, slave = detector.
interface seq_detector_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic               x;
  logic               x_valid;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               z;
  logic [CNT_W-1:0]   match_cnt;

  modport master (
    output x, x_valid,
    output cfg_we, cfg_pattern,
    output cfg_len, cfg_overlap,
    input  z, match_cnt
  );

  modport slave (
    input  x, x_valid,
    input  cfg_we, cfg_pattern,
    input  cfg_len, cfg_overlap,
    output z, match_cnt
  );
endinterface

// File: rtl/seq_detector_prog.sv
// Programmable Moore serial-pattern detector with saturating match counter.
// Ports: clk, rst_n (async low), bus (slave: x/x_valid/cfg_* in, z/match_cnt out).
module seq_detector_prog #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'('h0B),
  parameter int RST_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  seq_detector_prog_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic [MAX_LEN-1:0] r_pat;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_fcnt;
  logic               r_ovl;
  logic               r_z;
  logic [CNT_W-1:0]   r_cnt;

  logic [MAX_LEN-1:0] w_nh;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W:0]     w_fnext;
  logic               w_full;
  logic               w_hit;
  logic [LEN_W-1:0]   w_fsat;
  logic [LEN_W-1:0]   w_clen;
  logic               w_acc;

  assign w_nh    = {r_hist[MAX_LEN-2:0], bus.x};
  assign w_fnext = {1'b0, r_fcnt} + 1'b1;
  assign w_full  = w_fnext >= {1'b0, r_len};
  assign w_fsat  = w_full ? r_len
                          : w_fnext[LEN_W-1:0];
  assign w_acc   = bus.x_valid & ~bus.cfg_we;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++)
      w_mask[i] = (i < int'(r_len));
  end

  // Only the low len bits take part in the match.
  assign w_hit = w_full &&
    (((w_nh ^ r_pat) & w_mask) == '0);

  always_comb begin
    w_clen = bus.cfg_len;
    if (bus.cfg_len == '0)
      w_clen = LEN_W'(1);
    else if (bus.cfg_len > LEN_W'(MAX_LEN))
      w_clen = LEN_W'(MAX_LEN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat  <= RST_PAT;
      r_len  <= LEN_W'(RST_LEN);
      r_ovl  <= 1'b0;
      r_hist <= '0;
      r_fcnt <= '0;
      r_z    <= 1'b0;
      r_cnt  <= '0;
    end else begin
      unique case (1'b1)
        bus.cfg_we: begin
          r_pat  <= bus.cfg_pattern;
          r_len  <= w_clen;
          r_ovl  <= bus.cfg_overlap;
          r_hist <= '0;
          r_fcnt <= '0;
          r_z    <= 1'b0;
          r_cnt  <= '0;
        end
        w_acc: begin
          r_hist <= w_nh;
          r_z    <= w_hit;
          if (w_hit && r_cnt != '1)
            r_cnt <= r_cnt + 1'b1;
          // Non-overlap: matched bits are not reused.
          if (w_hit && !r_ovl)
            r_fcnt <= '0;
          else
            r_fcnt <= w_fsat;
        end
        default: ;
      endcase
    end
  end

  assign bus.z         = r_z;
  assign bus.match_cnt = r_cnt;
endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed bench for seq_detector_prog.
// Two instances: default widths and a 2-bit counter.
module tb_seq_detector_prog;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int ntests = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  seq_detector_prog_if #(.MAX_LEN(8), .CNT_W(8)) b ();
  seq_detector_prog_if #(.MAX_LEN(8), .CNT_W(2)) b2 ();

  seq_detector_prog #(.MAX_LEN(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );
  seq_detector_prog #(.MAX_LEN(8), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n, input logic ez,
                      input int ec, input string tag);
    for (int i = 0; i < n; i++) begin
      b.x = 1'b1;
      b.x_valid = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_z"}, 32'(b.z), 32'(ez));
      chk({tag, "_c"}, 32'(b.match_cnt), ec);
    end
  endtask

  task automatic seq(input logic [15:0] bits, input int n,
                     input logic [15:0] ez, input int ec,
                     input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      b.x = bits[i];
      b.x_valid = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("%s_z%0d", tag, n - 1 - i),
          32'(b.z), 32'(ez[i]));
    end
    b.x_valid = 1'b0;
    chk({tag, "_cnt"}, 32'(b.match_cnt), ec);
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [3:0] len,
                     input logic ovl, input string tag);
    b.cfg_we = 1'b1;
    b.cfg_pattern = pat;
    b.cfg_len = len;
    b.cfg_overlap = ovl;
    @(posedge clk); #1;
    b.cfg_we = 1'b0;
    b.x_valid = 1'b0;
    chk({tag, "_z"}, 32'(b.z), 32'd0);
    chk({tag, "_c"}, 32'(b.match_cnt), 32'd0);
  endtask

  initial begin
    b.x = 1'b0; b.x_valid = 1'b0; b.cfg_we = 1'b0;
    b.cfg_pattern = '0; b.cfg_len = '0; b.cfg_overlap = 1'b0;
    b2.x = 1'b0; b2.x_valid = 1'b0; b2.cfg_we = 1'b0;
    b2.cfg_pattern = '0; b2.cfg_len = '0; b2.cfg_overlap = 1'b0;
    #12;
    chk("rst_z", 32'(b.z), 32'd0);
    chk("rst_c", 32'(b.match_cnt), 32'd0);
    chk("rst2_c", 32'(b2.match_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle(2, 1'b0, 0, "t0_idle");

    seq(16'b1011011, 7, 16'b0001000, 1, "t1");

    cfg(8'h0B, 4'd4, 1'b1, "t2_cfg");
    seq(16'b1011011, 7, 16'b0001001, 2, "t2");

    cfg(8'h0B, 4'd4, 1'b0, "t3_cfg");
    seq(16'b101, 3, 16'b000, 0, "t3a");
    idle(5, 1'b0, 0, "t3_idle0");
    seq(16'b1, 1, 16'b1, 1, "t3b");
    idle(3, 1'b1, 1, "t3_hold");
    seq(16'b0, 1, 16'b0, 1, "t3c");

    cfg(8'hA5, 4'd8, 1'b0, "t4_cfg8");
    seq(16'hA5A5, 16, 16'h0101, 2, "t4_a5");
    cfg(8'hA5, 4'd15, 1'b0, "t4_cfg15");
    seq(16'h00A5, 8, 16'h0001, 1, "t4_len15");
    cfg(8'h01, 4'd1, 1'b0, "t4_cfg1");
    seq(16'b1101, 4, 16'b1101, 3, "t4_len1");
    cfg(8'h00, 4'd0, 1'b0, "t4_cfg0");
    seq(16'b01, 2, 16'b10, 1, "t4_len0");

    cfg(8'h0B, 4'd4, 1'b0, "t5_cfg");
    seq(16'b101, 3, 16'b000, 0, "t5a");
    cfg(8'h0B, 4'd4, 1'b0, "t5_recfg");
    seq(16'b1, 1, 16'b0, 0, "t5_part");
    b.x = 1'b1;
    b.x_valid = 1'b1;
    cfg(8'h03, 4'd2, 1'b0, "t5_cfgx");
    seq(16'b1, 1, 16'b0, 0, "t5_xign");
    seq(16'b1, 1, 16'b1, 1, "t5_hit");
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_z", 32'(b.z), 32'd0);
    chk("t5_rst_c", 32'(b.match_cnt), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    seq(16'b1011011, 7, 16'b0001000, 1, "t5_dflt");

    b2.cfg_we = 1'b1;
    b2.cfg_pattern = 8'h01;
    b2.cfg_len = 4'd1;
    b2.cfg_overlap = 1'b1;
    @(posedge clk); #1;
    b2.cfg_we = 1'b0;
    chk("t6_cfg_c", 32'(b2.match_cnt), 32'd0);
    for (int i = 0; i < 6; i++) begin
      b2.x = 1'b1;
      b2.x_valid = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("t6_z%0d", i), 32'(b2.z), 32'd1);
      chk($sformatf("t6_c%0d", i), 32'(b2.match_cnt),
          (i < 3) ? i + 1 : 3);
    end
    b2.x_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
